// File: rtl/future_round_ctrl_pkg.sv
// Shared types and constants for the round controller: FSM encoding, column
// count, key rotation amount, round-counter width and the key-update function.
package future_round_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MIX,
      ADDKEY,
      DONE
   } fsm_t;

   localparam int unsigned COLS    = 4;
   localparam int unsigned KEY_ROT = 13;
   localparam int unsigned ROUND_W = 5;

   typedef logic [ROUND_W-1:0] round_t;

   // Next round key: rotate left by KEY_ROT, then fold (round+1) into the low bits.
   function automatic logic [63:0] next_key(input logic [63:0] key, input round_t round);
      logic [63:0] k;
      round_t      r1;
      k      = {key[63-KEY_ROT:0], key[63:64-KEY_ROT]};
      r1     = round + 5'd1;
      k[4:0] = k[4:0] ^ r1;
      return k;
   endfunction

endpackage

// File: rtl/future_round_ctrl.sv
// Iterative round controller: per round, four columns pass through an external
// 16-bit mixing layer, then the round key is added and advanced.
module future_round_ctrl
   import future_round_ctrl_pkg::*;
#(
   parameter int unsigned NR = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   output logic [15:0] mix_din,
   input  logic [15:0] mix_dout,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   fsm_t        st;
   logic [1:0]  col;
   round_t      round;
   logic [63:0] state;
   logic [63:0] key;

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= IDLE;
         col   <= '0;
         round <= '0;
         state <= '0;
         key   <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (in_valid) begin
                  state <= in_data;
                  key   <= in_key;
                  round <= '0;
                  col   <= '0;
                  st    <= MIX;
               end
            end
            MIX: begin
               state[{col, 4'b0000} +: 16] <= mix_dout;
               col <= col + 2'd1;
               if (col == 2'(COLS - 1)) st <= ADDKEY;
            end
            ADDKEY: begin
               state <= state ^ key;
               key   <= next_key(key, round);
               round <= round + 5'd1;
               col   <= '0;
               if (round == round_t'(NR - 1)) st <= DONE;
               else                           st <= MIX;
            end
            DONE: begin
               if (out_ready) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Handshake outputs are masked by rst so they read inactive during the reset cycle itself.
   assign in_ready  = !rst && (st == IDLE);
   assign out_valid = !rst && (st == DONE);
   assign busy      = !rst && (st != IDLE);
   assign mix_din   = (!rst && (st == MIX)) ? state[{col, 4'b0000} +: 16] : '0;
   assign out_data  = state;

endmodule

// File: tb/tb_future_round_ctrl.sv
// Bench for future_round_ctrl: three instances (NR=1, 2, 16) checked every cycle
// against a cycle-timeline model of the cipher, plus hand-computed expectations.
module tb_future_round_ctrl;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv    [NI];
   logic        ordy  [NI];
   logic        irdy  [NI];
   logic        ov    [NI];
   logic        bsy   [NI];
   logic [63:0] idata [NI];
   logic [63:0] ikey  [NI];
   logic [63:0] odata [NI];
   logic [15:0] mdin  [NI];
   logic [15:0] mdout [NI];
   bit          mixm  [NI];

   int checks = 0;
   int errors = 0;

   bit          act  [NI];
   int          off  [NI];
   logic [63:0] eout [NI];
   logic [15:0] emix [NI][64];

   always #5 clk = ~clk;

   function automatic int nr_of(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 16;
      endcase
   endfunction

   function automatic logic [15:0] mixf(input logic [15:0] x, input bit m);
      return m ? ({x[12:0], x[15:13]} ^ 16'h5A5A) : x;
   endfunction

   assign mdout[0] = mixf(mdin[0], mixm[0]);
   assign mdout[1] = mixf(mdin[1], mixm[1]);
   assign mdout[2] = mixf(mdin[2], mixm[2]);

   future_round_ctrl #(.NR(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idata[0]),
      .in_key(ikey[0]), .mix_din(mdin[0]), .mix_dout(mdout[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_data(odata[0]), .busy(bsy[0]));

   future_round_ctrl #(.NR(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idata[1]),
      .in_key(ikey[1]), .mix_din(mdin[1]), .mix_dout(mdout[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_data(odata[1]), .busy(bsy[1]));

   future_round_ctrl u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(idata[2]),
      .in_key(ikey[2]), .mix_din(mdin[2]), .mix_dout(mdout[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_data(odata[2]), .busy(bsy[2]));

   // Whole-block cipher; also records the column presented at each mixing step.
   function automatic logic [63:0] cipher(input int i, input logic [63:0] d,
                                          input logic [63:0] k, input int nr, input bit m);
      logic [63:0] s, kk;
      s  = d;
      kk = k;
      for (int r = 0; r < nr; r++) begin
         for (int c = 0; c < 4; c++) begin
            emix[i][r*4+c] = s[16*c +: 16];
            s[16*c +: 16]  = mixf(s[16*c +: 16], m);
         end
         s      = s ^ kk;
         kk     = {kk[50:0], kk[63:51]};
         kk[4:0] = kk[4:0] ^ 5'(r + 1);
      end
      return s;
   endfunction

   // Timeline model: off counts edges since accept; off==5*NR means result held.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            act[i] = 1'b0;
         end else if (!act[i]) begin
            if (iv[i]) begin
               act[i]  = 1'b1;
               off[i]  = 0;
               eout[i] = cipher(i, idata[i], ikey[i], nr_of(i), mixm[i]);
            end
         end else if (off[i] < 5 * nr_of(i)) begin
            off[i] = off[i] + 1;
         end else if (ordy[i]) begin
            act[i] = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, i, got, exp);
      end
   endtask

   task automatic compare_all();
      logic [15:0] em;
      for (int i = 0; i < NI; i++) begin
         if (rst || !act[i]) begin
            chk("in_ready", i, 64'(irdy[i]), 64'(!rst));
            chk("out_valid", i, 64'(ov[i]), 64'd0);
            chk("busy", i, 64'(bsy[i]), 64'd0);
            chk("mix_din", i, 64'(mdin[i]), 64'd0);
         end else if (off[i] < 5 * nr_of(i)) begin
            em = (off[i] % 5 < 4) ? emix[i][(off[i] / 5) * 4 + off[i] % 5] : 16'h0000;
            chk("in_ready", i, 64'(irdy[i]), 64'd0);
            chk("out_valid", i, 64'(ov[i]), 64'd0);
            chk("busy", i, 64'(bsy[i]), 64'd1);
            chk("mix_din", i, 64'(mdin[i]), 64'(em));
         end else begin
            chk("in_ready", i, 64'(irdy[i]), 64'd0);
            chk("out_valid", i, 64'(ov[i]), 64'd1);
            chk("busy", i, 64'(bsy[i]), 64'd1);
            chk("mix_din", i, 64'(mdin[i]), 64'd0);
            chk("out_data", i, odata[i], eout[i]);
         end
      end
   endtask

   task automatic wait_ready(input int i);
      int n = 0;
      @(negedge clk);
      while (!irdy[i] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!irdy[i]) chk("ready_timeout", i, 64'd0, 64'd1);
   endtask

   task automatic run_block(input int i, input logic [63:0] d, input logic [63:0] k,
                            input int hold, output logic [63:0] res, output int lat,
                            output int nzmix);
      wait_ready(i);
      idata[i] = d;
      ikey[i]  = k;
      iv[i]    = 1'b1;
      @(posedge clk);
      #1 iv[i] = 1'b0;
      lat   = 0;
      nzmix = 0;
      while (lat < 400) begin
         @(negedge clk);
         if (mdin[i] != 16'h0000) nzmix++;
         if (ov[i]) break;
         @(posedge clk);
         lat++;
      end
      if (!ov[i]) chk("done_timeout", i, 64'd0, 64'd1);
      res = odata[i];
      repeat (hold) @(negedge clk);
      chk("held_valid", i, 64'(ov[i]), 64'd1);
      chk("held_data", i, odata[i], res);
      ordy[i] = 1'b1;
      @(posedge clk);
      #1 ordy[i] = 1'b0;
      @(negedge clk);
      chk("idle_after_take", i, 64'(irdy[i]), 64'd1);
   endtask

   logic [63:0] res;
   int          lat, nz;

   initial begin
      for (int i = 0; i < NI; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; idata[i] = '0; ikey[i] = '0; mixm[i] = 1'b0;
      end
      fork
         forever begin
            @(negedge clk);
            compare_all();
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("post_reset_ready", i, 64'(irdy[i]), 64'd1);
         chk("post_reset_data", i, odata[i], 64'd0);
      end

      run_block(0, 64'h0, 64'h0, 0, res, lat, nz);
      chk("zero_result", 0, res, 64'h0);
      chk("nr1_latency", 0, 64'(lat), 64'd5);
      chk("zero_mix_cols", 0, 64'(nz), 64'd0);

      run_block(0, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 0, res, lat, nz);
      chk("invert_result", 0, res, 64'hFEDCBA9876543210);
      chk("nr1_mix_cols", 0, 64'(nz), 64'd4);
      chk("model_pin_col3", 0, 64'(emix[0][3]), 64'h0123);

      run_block(1, 64'h0, 64'h1, 0, res, lat, nz);
      chk("keyrot_result", 1, res, 64'h0000000000002000);
      chk("nr2_latency", 1, 64'(lat), 64'd10);

      mixm[1] = 1'b1;
      run_block(1, 64'hA5A5_0F0F_3C3C_9696, 64'h1357_9BDF_2468_ACE0, 10, res, lat, nz);
      chk("bp_latency", 1, 64'(lat), 64'd10);

      mixm[2] = 1'b1;
      run_block(2, 64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978, 2, res, lat, nz);
      chk("nr16_latency", 2, 64'(lat), 64'd80);
      chk("nr16_mix_cols_max", 2, 64'(nz <= 64), 64'd1);

      // Streaming with in_valid and out_ready held high: each is ignored outside its state.
      mixm[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b1;
      iv[0]   = 1'b1;
      for (int n = 0; n < 40; n++) begin
         idata[0] = 64'(n + 1) * 64'h9E3779B97F4A7C15;
         ikey[0]  = ~idata[0];
         @(negedge clk);
      end
      iv[0]   = 1'b0;
      repeat (8) @(negedge clk);
      ordy[0] = 1'b0;
      mixm[0] = 1'b0;
      mixm[1] = 1'b0;

      // Abort in round 1 MIX.
      wait_ready(1);
      idata[1] = 64'h1111_2222_3333_4444;
      ikey[1]  = 64'h5555_6666_7777_8888;
      iv[1]    = 1'b1;
      @(posedge clk);
      #1 iv[1] = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid", 1, 64'(ov[1]), 64'd0);
      chk("abort_busy", 1, 64'(bsy[1]), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_ready", 1, 64'(irdy[1]), 64'd1);
      chk("abort_idle_busy", 1, 64'(bsy[1]), 64'd0);
      run_block(1, 64'h0, 64'h1, 0, res, lat, nz);
      chk("after_abort_result", 1, res, 64'h0000000000002000);
      chk("after_abort_latency", 1, 64'(lat), 64'd10);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/future_round_ctrl.md
FUTURE_ROUND_CTRL -- requirements
Module: future_round_ctrl

Interface
REQ-001 Parameter NR, default 16: number of cipher rounds; legal range 1..31.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  a new block is offered.
REQ-005 in_ready  output  1  the block can accept a new block.
REQ-006 in_data  input  64  plaintext block; column k = bits [16k+15:16k].
REQ-007 in_key  input  64  initial round key, sampled together with in_data.
REQ-008 mix_din  output  16  column sent to the shared external 16-bit mixing layer.
REQ-009 mix_dout  input  16  combinational result of the mixing layer for mix_din, in the same cycle.
REQ-010 out_valid  output  1  out_data holds a finished block.
REQ-011 out_ready  input  1  the consumer takes the block.
REQ-012 out_data  output  64  result block; equals the internal state register.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL use four states: IDLE, MIX, ADDKEY, DONE; a 2-bit column index and a 5-bit round counter.
REQ-015 IDLE: in_ready=1; in_valid&in_ready loads state<=in_data, key<=in_key, round<=0, col<=0, and moves to MIX.
REQ-016 MIX: mix_din=state column col; state column col<=mix_dout; col increments; after col=3, move to ADDKEY.
REQ-017 Outside MIX, mix_din SHALL be 0.
REQ-018 ADDKEY: state<=state^key; key<=rotl13(key) with bits [4:0] XORed with (round+1); round increments.
REQ-019 ADDKEY exit: round==NR-1 goes to DONE, else goes to MIX with col=0.
REQ-020 Latency: if the accept edge is E, the FSM SHALL be in DONE (out_valid=1) after edge E+5*NR.
REQ-021 DONE: out_valid=1; out_data stays stable until out_ready=1, then the FSM goes to IDLE.
REQ-022 in_ready SHALL be 0 in DONE, so there is no same-cycle accept on completion; the next accept occurs no earlier than the cycle after IDLE is entered.
REQ-023 out_ready and in_valid SHALL be ignored outside DONE and IDLE respectively.
REQ-024 Backpressure of any length SHALL hold all registers in DONE unchanged.

Reset
REQ-025 rst SHALL force state=IDLE, col=0, round=0, and state/key registers to 0.
REQ-026 While rst is high: out_valid=0, in_ready=0, busy=0, mix_din=0.
REQ-027 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 A rst mid-operation (MIX, ADDKEY or DONE) SHALL abort the block with no out_valid pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, COLS=4, the KEY_ROT=13 constant, and the 5-bit round-counter width.
REQ-030 There are no sub-modules: the mixing layer is instantiated by the parent beside this controller and connected via mix_din/mix_dout; the key-update function SHALL be a package function.

Verification
REQ-031 NR=1, mix=identity, in_data=0, in_key=0: accept at E -> out_valid after E+5, out_data=0.
REQ-032 NR=1, mix=identity, in_data=0x0123456789ABCDEF, in_key=0xFFFFFFFFFFFFFFFF -> out_data=0xFEDCBA9876543210.
REQ-033 NR=2, mix=identity, in_data=0, in_key=0x0000000000000001 -> out_data=0x0000000000002000 after E+10.
REQ-034 Bench mix model records mix_din -> sequence is columns 0,1,2,3 per round, 4*NR nonzero-indexed entries, mix_din=0 elsewhere.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst in round 1 MIX -> next cycle out_valid=0, busy=0; a new block then completes with the correct result.
